hamming_pipe_arbiter: RTL

- Shares the 3-stage pipelined Hamming(15,11) codec (encode → error inject → decode/correct) among NREQ requesters.
- Arbitrates requests round-robin and drives the codec's data and error-position inputs.
- Tracks in-flight operations with a valid/tag shift register.
- Returns each corrected word, with its requester ID and a mismatch flag, through a credit-protected response FIFO. The codec pipeline itself cannot stall.

---
 rtl/hamming_pipe_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pipe_arbiter
// Purpose  : Round-robin front end that shares a 3-stage Hamming(15,11) codec
//            among NREQ requesters, with in-flight tracking and a
//            credit-protected response FIFO.
// Revision : 1.0  initial release
// ============================================================================

module hamming_pipe_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_W     = 11,
  parameter int ERR_W      = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic [NREQ*ERR_W-1:0]     req_err,
  output logic [DATA_W-1:0]         pipe_b,
  output logic [ERR_W-1:0]          pipe_e,
  output logic                      pipe_issue,
  input  logic [DATA_W-1:0]         pipe_q,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_mismatch
);

  localparam int IDW     = $clog2(NREQ);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + LAT + 1);
  localparam int ENTRY_W = IDW + DATA_W + 1;

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           credit_ok;
  int             cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant_q) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && credit_ok) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign pipe_issue   = |(req_valid & req_ready);
  // Idle cycles feed zeros so the codec sees deterministic traffic.
  assign pipe_b       = pipe_issue ? req_data[int'(grant_idx)*DATA_W +: DATA_W] : '0;
  assign pipe_e       = pipe_issue ? req_err[int'(grant_idx)*ERR_W +: ERR_W]    : '0;
  assign last_grant_d = pipe_issue ? grant_idx : last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight tracking, aligned so stage LAT-1 coincides with valid pipe_q
  // --------------------------------------------------------------------------
  logic [LAT-1:0]    sr_vld_q;
  logic [IDW-1:0]    sr_id_q  [LAT];
  logic [DATA_W-1:0] sr_dat_q [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        sr_id_q[i]  <= '0;
        sr_dat_q[i] <= '0;
      end
    end else begin
      sr_vld_q[0] <= pipe_issue;
      sr_id_q[0]  <= grant_idx;
      sr_dat_q[0] <= pipe_b;
      for (int i = 1; i < LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_id_q[i]  <= sr_id_q[i-1];
        sr_dat_q[i] <= sr_dat_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Credits: FIFO slots not yet claimed by stored or in-flight responses
  // --------------------------------------------------------------------------
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] inflight_cnt;
  logic [CW-1:0] used_cnt;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_cnt = inflight_cnt + CW'(sr_vld_q[i]);
    end
  end

  assign used_cnt  = inflight_cnt + CW'(count_q);
  assign credit_ok = !reset && (used_cnt < CW'(FIFO_DEPTH));

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;

  assign push       = sr_vld_q[LAT-1];
  assign pop        = rsp_ready && (count_q != '0);
  assign push_entry = {sr_id_q[LAT-1], pipe_q, (pipe_q != sr_dat_q[LAT-1])};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
      end
    end
  end

  // Head entry is presented straight from storage registers.
  assign head                               = mem_q[rd_ptr_q];
  assign rsp_valid                          = (count_q != '0);
  assign {rsp_id, rsp_data, rsp_mismatch}   = head;

endmodule

`default_nettype wire
